operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer_if.sv | 26 ++
 rtl/operand_sequencer.sv | 100 ++++++++++
 tb/tb_operand_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_sequencer_if.sv
// Host request/result signals and the nibble-serial engine bus for operand_sequencer.
interface operand_sequencer_if;
  logic               start;
  logic [3:0]         x_in, dx_in, u_in, a_in;
  logic               busy;
  logic signed [14:0] result;
  logic               res_valid;
  logic               timeout;
  logic [3:0]         fsm_in;
  logic               fsm_s1, fsm_s2, fsm_s3, fsm_s4;
  logic               fsm_ready;
  logic signed [14:0] fsm_out;
  logic               fsm_valid;

  modport slave (
    input  start, x_in, dx_in, u_in, a_in, fsm_out, fsm_valid,
    output busy, result, res_valid, timeout,
           fsm_in, fsm_s1, fsm_s2, fsm_s3, fsm_s4, fsm_ready
  );

  modport master (
    output start, x_in, dx_in, u_in, a_in, fsm_out, fsm_valid,
    input  busy, result, res_valid, timeout,
           fsm_in, fsm_s1, fsm_s2, fsm_s3, fsm_s4, fsm_ready
  );
endinterface

// File: rtl/operand_sequencer.sv
// Streams four captured operands to the engine one nibble per cycle, fires the
// start strobe, then waits for completion or aborts after TIMEOUT_CYCLES.
module operand_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic                clk,
  input  logic                rst,
  operand_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LX, LDX, LU, LA, RDY, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         x_q, dx_q, u_q, a_q;
  logic signed [14:0] result_q;
  logic               res_valid_q;
  logic               timeout_q;

  logic [3:0]         ld_nib;
  logic [3:0]         ld_strb;
  logic               ld_ready;

  // Engine-side bus is a pure Moore decode of the state, so it is glitch-free
  // and drops to zero the instant reset forces IDLE.
  always_comb begin
    ld_nib   = '0;
    ld_strb  = '0;
    ld_ready = 1'b0;
    case (state_q)
      LX:  begin ld_nib = x_q;  ld_strb = 4'b0001; end
      LDX: begin ld_nib = dx_q; ld_strb = 4'b0010; end
      LU:  begin ld_nib = u_q;  ld_strb = 4'b0100; end
      LA:  begin ld_nib = a_q;  ld_strb = 4'b1000; end
      RDY: ld_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      dx_q        <= '0;
      u_q         <= '0;
      a_q         <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          x_q     <= bus.x_in;
          dx_q    <= bus.dx_in;
          u_q     <= bus.u_in;
          a_q     <= bus.a_in;
          state_q <= LX;
        end
        LX:  state_q <= LDX;
        LDX: state_q <= LU;
        LU:  state_q <= LA;
        LA:  state_q <= RDY;
        RDY: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        // Completion wins over expiry when both land on the same edge.
        WAIT: if (bus.fsm_valid) begin
          result_q    <= bus.fsm_out;
          res_valid_q <= 1'b1;
          state_q     <= IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_q <= 1'b1;
          state_q   <= IDLE;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.fsm_in    = ld_nib;
  assign bus.fsm_s1    = ld_strb[0];
  assign bus.fsm_s2    = ld_strb[1];
  assign bus.fsm_s3    = ld_strb[2];
  assign bus.fsm_s4    = ld_strb[3];
  assign bus.fsm_ready = ld_ready;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: every observable event is logged with its cycle
// number and compared against a timeline built from operands and engine delay.
module tb_operand_sequencer;
  localparam int TO = 8;

  typedef logic [63:0] ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  operand_sequencer_if bus();

  operand_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Engine model: answers eng_delay cycles after seeing fsm_ready (0 = never).
  int                 eng_delay = 0;
  int                 eng_cnt = 0;
  logic               eng_valid = 1'b0;
  logic signed [14:0] eng_val = '0;
  logic               stray_valid = 1'b0;
  logic signed [14:0] stray_out = 15'h1234;

  assign bus.fsm_valid = stray_valid | eng_valid;
  assign bus.fsm_out   = stray_valid ? stray_out : eng_val;

  always @(negedge clk) begin
    eng_valid = 1'b0;
    if (!rst) eng_cnt = 0;
    else if (bus.fsm_ready) eng_cnt = eng_delay;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_valid = 1'b1;
    end
  end

  function automatic ev_t mk(int c, int k, logic [4:0] s, logic [15:0] v);
    return {32'(c), 8'(k), 3'b000, s, v};
  endfunction

  ev_t ev_log[$];
  int  busy_cnt = 0;

  always @(negedge clk) begin
    logic [4:0] st;
    st = {bus.fsm_ready, bus.fsm_s4, bus.fsm_s3, bus.fsm_s2, bus.fsm_s1};
    if (st != 5'b0 || bus.fsm_in != 4'b0) ev_log.push_back(mk(cyc, 1, st, {12'b0, bus.fsm_in}));
    if (bus.res_valid) ev_log.push_back(mk(cyc, 2, 5'b0, {1'b0, bus.result}));
    if (bus.timeout)   ev_log.push_back(mk(cyc, 3, 5'b0, 16'b0));
    if (bus.busy) busy_cnt++;
  end

  // Reference model state
  ev_t                ex[$];
  int                 exp_busy;
  logic signed [14:0] model_result = '0;

  // One run whose LX cycle is s: four nibbles then ready, then either the
  // engine answer after d cycles or expiry after TO waiting cycles. abort>0
  // means reset fell during cycle 'abort'.
  task automatic model_run(input int s, input logic [3:0] x, dx, u, a, input int d,
                           input logic signed [14:0] out, input int abort, output int p);
    logic [3:0] nib [5];
    nib = '{x, dx, u, a, 4'h0};
    for (int k = 0; k < 5; k++)
      if (abort == 0 || s + k <= abort) ex.push_back(mk(s + k, 1, 5'(1 << k), {12'b0, nib[k]}));
    if (abort != 0) begin
      p = abort;
      exp_busy += abort - s + 1;
      model_result = '0;
    end else if (d >= 1 && d <= TO) begin
      p = s + 5 + d;
      model_result = out;
      ex.push_back(mk(p, 2, 5'b0, {1'b0, model_result}));
      exp_busy += p - s;
    end else begin
      p = s + 5 + TO;
      ex.push_back(mk(p, 3, 5'b0, 16'b0));
      exp_busy += p - s;
    end
  endtask

  task automatic launch(input logic [3:0] x, dx, u, a, output int s);
    @(negedge clk);
    bus.start = 1'b1; bus.x_in = x; bus.dx_in = dx; bus.u_in = u; bus.a_in = a;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_in = 4'($urandom); bus.dx_in = 4'($urandom); bus.u_in = 4'($urandom); bus.a_in = 4'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.result !== 15'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++;
    if ({bus.res_valid, bus.timeout, bus.fsm_ready, bus.fsm_s4, bus.fsm_s3, bus.fsm_s2, bus.fsm_s1} !== 7'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 0", {bus.res_valid, bus.timeout, bus.fsm_ready,
                          bus.fsm_s4, bus.fsm_s3, bus.fsm_s2, bus.fsm_s1});
    end
    checks++; if (bus.fsm_in !== 4'd0) begin errors++; $display("FAIL reset_fsm_in got %h want 0", bus.fsm_in); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_nominal;
    int eb, bb, s, p;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    eng_delay = 2; eng_val = -15'sd100;
    launch(4'd3, 4'd1, 4'd5, 4'd2, s);
    model_run(s, 4'd3, 4'd1, 4'd5, 4'd2, 2, -15'sd100, 0, p);
    wait_until(p + 2);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL nominal event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL nominal ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (busy_cnt - bb !== exp_busy) begin errors++; $display("FAIL nominal busy_cycles got %0d want %0d", busy_cnt - bb, exp_busy); end
    checks++; if (bus.result !== -15'sd100) begin errors++; $display("FAIL nominal result got %0d want -100", bus.result); end
  endtask

  task automatic test_timeout;
    int eb, bb, s, p;
    logic [3:0] x, dx, u, a;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    x = 4'($urandom); dx = 4'($urandom); u = 4'($urandom); a = 4'($urandom);
    eng_delay = 0;
    launch(x, dx, u, a, s);
    model_run(s, x, dx, u, a, 0, '0, 0, p);
    wait_until(p + 2);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL timeout event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL timeout ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (busy_cnt - bb !== exp_busy) begin errors++; $display("FAIL timeout busy_cycles got %0d want %0d", busy_cnt - bb, exp_busy); end
    checks++; if (bus.result !== model_result) begin errors++; $display("FAIL timeout result_held got %h want %h", bus.result, model_result); end
  endtask

  task automatic test_race;
    int eb, bb, s, p;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    eng_delay = TO; eng_val = 15'h3FFF;
    launch(4'hA, 4'h5, 4'hF, 4'h1, s);
    model_run(s, 4'hA, 4'h5, 4'hF, 4'h1, TO, 15'h3FFF, 0, p);
    wait_until(p + 2);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL race event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL race ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (bus.result !== 15'h3FFF) begin errors++; $display("FAIL race result got %h want 3fff", bus.result); end
  endtask

  task automatic test_busy_start;
    int eb, bb, s, p;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    eng_delay = 3; eng_val = 15'sd1234;
    launch(4'h2, 4'h4, 4'h6, 4'h8, s);
    model_run(s, 4'h2, 4'h4, 4'h6, 4'h8, 3, 15'sd1234, 0, p);
    wait_until(s + 2);
    bus.start = 1'b1; bus.x_in = 4'd9; bus.dx_in = 4'hE; bus.u_in = 4'hD; bus.a_in = 4'hC;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(p + 8);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL busy_start event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL busy_start ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (busy_cnt - bb !== exp_busy) begin errors++; $display("FAIL busy_start busy_cycles got %0d want %0d", busy_cnt - bb, exp_busy); end
  endtask

  task automatic test_stray_valid;
    int eb, bb, s, p;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    eng_delay = 3; eng_val = -15'sd77;
    @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    launch(4'h1, 4'h3, 4'h7, 4'hB, s);
    model_run(s, 4'h1, 4'h3, 4'h7, 4'hB, 3, -15'sd77, 0, p);
    wait_until(s + 5);
    stray_valid = 1'b0;
    wait_until(p + 2);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL stray event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL stray ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (bus.result !== -15'sd77) begin errors++; $display("FAIL stray result got %h want %h", bus.result, -15'sd77); end
  endtask

  task automatic test_reset_mid;
    int eb, bb, s, p;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    eng_delay = 0;
    launch(4'h6, 4'h6, 4'h6, 4'h6, s);
    model_run(s, 4'h6, 4'h6, 4'h6, 4'h6, 0, '0, s + 7, p);
    wait_until(s + 7);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
    checks++; if (bus.result !== 15'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", bus.result); end
    checks++;
    if ({bus.res_valid, bus.timeout, bus.fsm_ready, bus.fsm_s4, bus.fsm_s3, bus.fsm_s2, bus.fsm_s1, bus.fsm_in} !== 11'b0) begin
      errors++; $display("FAIL rstmid_outputs got %b want 0", {bus.res_valid, bus.timeout, bus.fsm_ready,
                          bus.fsm_s4, bus.fsm_s3, bus.fsm_s2, bus.fsm_s1, bus.fsm_in});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    eng_delay = 2; eng_val = 15'sd321;
    launch(4'd7, 4'h0, 4'h9, 4'h3, s);
    model_run(s, 4'd7, 4'h0, 4'h9, 4'h3, 2, 15'sd321, 0, p);
    wait_until(p + 2);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL rstmid event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL rstmid ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (busy_cnt - bb !== exp_busy) begin errors++; $display("FAIL rstmid busy_cycles got %0d want %0d", busy_cnt - bb, exp_busy); end
  endtask

  task automatic test_back_to_back;
    int eb, bb, s, p;
    logic [3:0] x, dx, u, a;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    x = 4'($urandom); dx = 4'($urandom); u = 4'($urandom); a = 4'($urandom);
    eng_delay = 1; eng_val = 15'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.x_in = x; bus.dx_in = dx; bus.u_in = u; bus.a_in = a;
    s = cyc + 1;
    for (int r = 0; r < 3; r++) begin
      model_run(s, x, dx, u, a, 1, eng_val, 0, p);
      s = p + 1;
    end
    wait_until(p - 1);
    bus.start = 1'b0;
    wait_until(p + 3);
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL b2b event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL b2b ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (busy_cnt - bb !== exp_busy) begin errors++; $display("FAIL b2b busy_cycles got %0d want %0d", busy_cnt - bb, exp_busy); end
  endtask

  task automatic test_random;
    int eb, bb, s, p, d;
    logic [3:0] x, dx, u, a;
    eb = ev_log.size(); bb = busy_cnt; ex.delete(); exp_busy = 0;
    for (int r = 0; r < 10; r++) begin
      x = 4'($urandom); dx = 4'($urandom); u = 4'($urandom); a = 4'($urandom);
      d = int'($urandom_range(10, 0));
      eng_delay = d; eng_val = 15'($urandom);
      launch(x, dx, u, a, s);
      model_run(s, x, dx, u, a, d, eng_val, 0, p);
      wait_until(p + int'($urandom_range(3, 1)));
    end
    checks++; if (ev_log.size() - eb !== ex.size()) begin errors++; $display("FAIL random event_count got %0d want %0d", ev_log.size() - eb, ex.size()); end
    foreach (ex[i]) begin
      ev_t got = (eb + i < ev_log.size()) ? ev_log[eb + i] : '0;
      checks++; if (got !== ex[i]) begin errors++; $display("FAIL random ev%0d got %h want %h", i, got, ex[i]); end
    end
    checks++; if (busy_cnt - bb !== exp_busy) begin errors++; $display("FAIL random busy_cycles got %0d want %0d", busy_cnt - bb, exp_busy); end
    checks++; if (bus.result !== model_result) begin errors++; $display("FAIL random final_result got %h want %h", bus.result, model_result); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x_in = '0; bus.dx_in = '0; bus.u_in = '0; bus.a_in = '0;
    test_reset();
    test_nominal();
    test_timeout();
    test_race();
    test_busy_start();
    test_stray_valid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
